toggle_acc_arbiter: RTL and testbench
=====================================

# toggle_acc_arbiter

Round-robin controller that shares one XOR-feedback toggle accumulator (dout <= dout ^ din) between two serial bit-stream requesters. A requester wins a grant and streams exactly FRAME_LEN bits through the accumulator. The block then reports the frame parity and the winning requester's ID, and moves to the next requester. It sits in front of the single-bit toggle datapath and schedules access to it.

## Interface
- FRAME_LEN, 8: bits per frame; must be ≥ 1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  bit i high: requester i presents a bit.
- req_bit  in  2  data bit from requester i.
- req_ready  out  2  one-hot grant. A bit is accepted when req_valid[i] & req_ready[i].
- acc  out  1  current accumulator (toggle flop) value.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- parity  out  1  parity of the last completed frame; held until the next done.
- owner  out  1  requester ID of the last completed frame; held until the next done.

## Operation
- Reset values:
  - state IDLE; acc, parity, owner, done and busy are 0; req_ready = 00.
  - Priority pointer favours requester 0.
- Bit counter width is max(1, $clog2(FRAME_LEN)). The counter counts accepted bits, from 0 to FRAME_LEN-1.
- IDLE:
  - req_ready = 00.
  - If any req_valid bit is set, choose the grantee. If both are valid, the requester named by the priority pointer wins. Otherwise the sole valid requester wins.
  - On that edge: latch the grantee, clear acc to 0, clear the counter, go to STREAM.
  - If no req_valid bit is set, stay in IDLE; acc holds.
- STREAM:
  - req_ready = one-hot of the grantee. The other requester is ignored even if valid.
  - On an accept: acc <= acc ^ req_bit[grantee], and the counter increments.
  - If the grantee's valid is low, this is a stall: acc and the counter hold. There is no timeout.
  - On the accept where counter == FRAME_LEN-1: go to DONE; parity <= acc ^ bit; owner <= grantee.
- DONE (exactly one cycle):
  - done = 1; req_ready = 00.
  - Priority pointer <= the non-grantee.
  - Next state IDLE.
- busy = 1 in STREAM and DONE.
- All outputs are driven from registers or from decoded state and grantee. There is no combinational path from inputs to outputs.
- Reset asserted in any state:
  - Next cycle is IDLE with reset values. The partial frame is discarded and no done is issued.
  - parity and owner clear to 0, and the pointer returns to 0.

## Timing
- req_valid is first seen in IDLE at cycle t.
  - Grant (req_ready) is high at t+1, with acc = 0.
  - With no stalls, the last accept is at t+FRAME_LEN.
  - done, parity and owner are valid at t+FRAME_LEN+1, and the block is back in IDLE at t+FRAME_LEN+2.
- With continuous valid on both requesters:
  - Period is FRAME_LEN+2 cycles per frame.
  - Grants alternate 0, 1, 0, 1, …
  - req_ready is never 11.
- Each stall cycle extends the frame by one cycle.
- FRAME_LEN = 1: the first accept goes straight to DONE.
- acc shows the running XOR of the bits accepted so far in the frame, one cycle after each accept.

## Test plan
- Reset check: hold reset 3 cycles with both requesters valid → req_ready = 00, and acc, done, busy, parity, owner are all 0 throughout.
- Single frame, FRAME_LEN = 8: requester 0 streams 1,0,1,1,0,0,0,1 back-to-back → 8 consecutive accepts; then done = 1, parity = 0, owner = 0 one cycle after the last accept.
  - acc trace: 1,1,0,1,1,1,1,0.
- Contention: both requesters valid continuously, requester 1 sends all ones → grants go 0, 1, 0 with a 10-cycle period.
  - Requester 1's frame: parity = 0 (eight ones).
  - req_ready never 11; the non-granted valid is never consumed.
- Stall: requester 0 drops valid for 3 cycles after its 3rd bit, with bits 1,1,1,0,0,0,0,0 → acc stays 1 during the stall; done arrives 3 cycles later than the no-stall case, with parity = 1.
- Reset mid-frame: assert reset after 4 accepted bits → next cycle IDLE, acc = 0, no done pulse.
  - With both requesters then valid, requester 0 is granted first.
- FRAME_LEN = 1 instance: requester 1 alone streams 1,0,1 → done every 3 cycles, with parity 1, 0, 1 and owner = 1.

Source files
------------

// File: rtl/toggle_acc_arbiter.sv
// toggle_acc_arbiter: round-robin scheduler that lends one XOR-feedback toggle
// accumulator to two serial bit-stream requesters, one FRAME_LEN-bit frame at a
// time, and reports each frame's parity and owner.
module toggle_acc_arbiter #(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_bit,
  output logic [1:0] req_ready,
  output logic       acc,
  output logic       busy,
  output logic       done,
  output logic       parity,
  output logic       owner
);

  localparam int unsigned   CW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          grantee;
  logic          ptr;
  logic          pick;
  logic          accept;
  logic          last_bit;
  logic          cur_bit;
  logic [CW-1:0] cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, grant choice and outputs decoded from state and grantee only.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    pick      = ptr;
    cur_bit   = req_bit[grantee];
    accept    = 1'b0;
    last_bit  = (cnt == LAST);

    if (req_valid == 2'b01)      pick = 1'b0;
    else if (req_valid == 2'b10) pick = 1'b1;

    case (state)
      S_IDLE: begin
        if (|req_valid) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        busy      = 1'b1;
        req_ready = grantee ? 2'b10 : 2'b01;
        accept    = req_valid[grantee];
        if (accept && last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, bit counter, grantee/pointer and frame result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= 1'b0;
      cnt     <= '0;
      grantee <= 1'b0;
      ptr     <= 1'b0;
      parity  <= 1'b0;
      owner   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            grantee <= pick;
            acc     <= 1'b0;
            cnt     <= '0;
          end
        end
        S_STREAM: begin
          if (accept) begin
            acc <= acc ^ cur_bit;
            cnt <= last_bit ? '0 : cnt + 1'b1;
            if (last_bit) begin
              parity <= acc ^ cur_bit;
              owner  <= grantee;
            end
          end
        end
        S_DONE: begin
          ptr <= ~grantee;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_acc_arbiter.sv
// Bench for toggle_acc_arbiter: FRAME_LEN=8 and FRAME_LEN=1 instances driven by
// directed scenarios followed by random traffic, checked every cycle against a
// frame-level reference model.
module tb_toggle_acc_arbiter;

  logic       clk = 1'b0;
  logic       r8, r1;
  logic [1:0] v8, v1, b8, b1;
  logic [1:0] rdy8, rdy1;
  logic       acc8, busy8, done8, par8, own8;
  logic       acc1, busy1, done1, par1, own1;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = FRAME_LEN 8, index 1 = FRAME_LEN 1.
  // phase: 0 waiting for a request, 1 frame in progress, 2 report cycle.
  int   m_phase[2];
  int   m_cnt[2];
  logic m_who[2];
  logic m_ptr[2];
  logic m_acc[2];
  logic m_par[2];
  logic m_own[2];

  // Directed bit sources.
  logic [7:0] pat8[2];
  int         idx8[2];
  logic [2:0] pat1 = 3'b101;
  int         idx1 = 0;
  bit         use_pat = 1'b1;

  toggle_acc_arbiter #(.FRAME_LEN(8)) dut8 (
    .clk(clk), .reset(r8), .req_valid(v8), .req_bit(b8), .req_ready(rdy8),
    .acc(acc8), .busy(busy8), .done(done8), .parity(par8), .owner(own8)
  );

  toggle_acc_arbiter #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .reset(r1), .req_valid(v1), .req_bit(b1), .req_ready(rdy1),
    .acc(acc1), .busy(busy1), .done(done1), .parity(par1), .owner(own1)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model; returns which requesters had a bit taken.
  function automatic logic [1:0] model_step(input int k, input logic r,
                                            input logic [1:0] v, input logic [1:0] b);
    logic [1:0] take;
    int         flen;
    take = 2'b00;
    flen = (k == 0) ? 8 : 1;
    if (r) begin
      m_phase[k] = 0; m_cnt[k] = 0; m_who[k] = 1'b0; m_ptr[k] = 1'b0;
      m_acc[k] = 1'b0; m_par[k] = 1'b0; m_own[k] = 1'b0;
    end else if (m_phase[k] == 0) begin
      if (v != 2'b00) begin
        m_who[k]   = (v == 2'b11) ? m_ptr[k] : v[1];
        m_acc[k]   = 1'b0;
        m_cnt[k]   = 0;
        m_phase[k] = 1;
      end
    end else if (m_phase[k] == 1) begin
      if (v[m_who[k]]) begin
        take[m_who[k]] = 1'b1;
        m_acc[k] = m_acc[k] ^ b[m_who[k]];
        m_cnt[k]++;
        if (m_cnt[k] == flen) begin
          m_par[k]   = m_acc[k];
          m_own[k]   = m_who[k];
          m_phase[k] = 2;
        end
      end
    end else begin
      m_ptr[k]   = ~m_who[k];
      m_phase[k] = 0;
    end
    return take;
  endfunction

  task automatic cmp_dut(input string nm, input int k, input logic [1:0] rdy,
                         input logic a, input logic d, input logic bz,
                         input logic p, input logic o);
    logic [1:0] e_rdy;
    e_rdy = (m_phase[k] == 1) ? (m_who[k] ? 2'b10 : 2'b01) : 2'b00;
    chk2({nm, ".req_ready"}, rdy, e_rdy);
    chk1({nm, ".acc"}, a, m_acc[k]);
    chk1({nm, ".done"}, d, m_phase[k] == 2);
    chk1({nm, ".busy"}, bz, m_phase[k] != 0);
    chk1({nm, ".parity"}, p, m_par[k]);
    chk1({nm, ".owner"}, o, m_own[k]);
    chk1({nm, ".ready_not_11"}, rdy != 2'b11, 1'b1);
  endtask

  task automatic drive_bits();
    if (use_pat) begin
      b8[0] = pat8[0][idx8[0] % 8];
      b8[1] = pat8[1][idx8[1] % 8];
      b1    = {pat1[idx1 % 3], 1'b0};
    end
  endtask

  task automatic step();
    logic [1:0] t8, t1;
    @(posedge clk);
    t8 = model_step(0, r8, v8, b8);
    t1 = model_step(1, r1, v1, b1);
    if (t8[0]) idx8[0]++;
    if (t8[1]) idx8[1]++;
    if (t1[1]) idx1++;
    #1;
    cmp_dut("dut8", 0, rdy8, acc8, done8, busy8, par8, own8);
    cmp_dut("dut1", 1, rdy1, acc1, done1, busy1, par1, own1);
    drive_bits();
  endtask

  initial begin
    logic [7:0] trace;
    pat8[0] = 8'h00; pat8[1] = 8'h00; idx8[0] = 0; idx8[1] = 0;
    for (int k = 0; k < 2; k++) void'(model_step(k, 1'b1, 2'b00, 2'b00));

    // Reset held with both requesters valid.
    r8 = 1'b1; r1 = 1'b1; v8 = 2'b11; v1 = 2'b11; b8 = 2'b11; b1 = 2'b11;
    for (int s = 0; s < 3; s++) begin
      step();
      chk2("rst.ready8", rdy8, 2'b00);
      chk1("rst.busy8", busy8, 1'b0);
      chk1("rst.acc8", acc8, 1'b0);
      chk2("rst.ready1", rdy1, 2'b00);
    end

    // Single frame from requester 0: 1,0,1,1,0,0,0,1.
    r8 = 1'b0; r1 = 1'b0; v1 = 2'b00;
    pat8[0] = 8'b1000_1101; idx8[0] = 0; drive_bits();
    trace = 8'b0111_1011;
    v8 = 2'b01;
    step();
    chk2("single.grant", rdy8, 2'b01);
    chk1("single.acc0", acc8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk1("single.acc_trace", acc8, trace[k]);
    end
    chk1("single.done", done8, 1'b1);
    chk1("single.parity", par8, 1'b0);
    chk1("single.owner", own8, 1'b0);
    v8 = 2'b00;
    step();
    chk1("single.idle", busy8, 1'b0);

    // Contention after reset: requester 1 sends all ones.
    r8 = 1'b1; step(); r8 = 1'b0;
    pat8[0] = 8'($urandom); pat8[1] = 8'hFF; idx8[0] = 0; idx8[1] = 0; drive_bits();
    v8 = 2'b11;
    for (int s = 1; s <= 30; s++) begin
      step();
      if (s == 1)  chk2("cont.grant_a", rdy8, 2'b01);
      if (s == 11) chk2("cont.grant_b", rdy8, 2'b10);
      if (s == 21) chk2("cont.grant_c", rdy8, 2'b01);
      if (s == 9 || s == 19 || s == 29) begin
        chk1("cont.done", done8, 1'b1);
        chk1("cont.owner", own8, s == 19);
      end
      if (s == 19) chk1("cont.parity1", par8, 1'b0);
    end
    v8 = 2'b00;
    step();

    // Stall of 3 cycles after the 3rd bit; bits 1,1,1,0,0,0,0,0.
    pat8[0] = 8'b0000_0111; idx8[0] = 0; drive_bits();
    v8 = 2'b01;
    step();
    chk2("stall.grant", rdy8, 2'b01);
    for (int k = 0; k < 3; k++) step();
    v8 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("stall.acc_hold", acc8, 1'b1);
      chk1("stall.busy", busy8, 1'b1);
    end
    v8 = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("stall.no_early_done", done8, 1'b0);
    end
    step();
    chk1("stall.done", done8, 1'b1);
    chk1("stall.parity", par8, 1'b1);
    v8 = 2'b00;
    step();

    // Reset after 4 accepted bits; pointer must return to requester 0.
    pat8[0] = 8'($urandom); idx8[0] = 0; drive_bits();
    v8 = 2'b01;
    for (int k = 0; k < 5; k++) step();
    r8 = 1'b1;
    step();
    chk2("midrst.ready", rdy8, 2'b00);
    chk1("midrst.acc", acc8, 1'b0);
    chk1("midrst.done", done8, 1'b0);
    chk1("midrst.busy", busy8, 1'b0);
    r8 = 1'b0; v8 = 2'b11;
    step();
    chk2("midrst.regrant", rdy8, 2'b01);
    v8 = 2'b00;
    for (int k = 0; k < 10; k++) step();

    // FRAME_LEN=1 instance: requester 1 alone streams 1,0,1.
    idx1 = 0; drive_bits();
    v1 = 2'b10;
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s == 2 || s == 5 || s == 8) begin
        chk1("fl1.done", done1, 1'b1);
        chk1("fl1.parity", par1, s != 5);
        chk1("fl1.owner", own1, 1'b1);
      end
    end
    v1 = 2'b00;
    step();

    // Random traffic with occasional resets on both instances.
    use_pat = 1'b0;
    for (int s = 0; s < 400; s++) begin
      v8 = 2'($urandom); b8 = 2'($urandom); r8 = ($urandom_range(0, 49) == 0);
      v1 = 2'($urandom); b1 = 2'($urandom); r1 = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
